// File: rtl/chirp_uart_rx_if.sv
// Downstream byte/status bus of the chirp configuration UART receiver.
// The receiver drives it through the master modport; consumers use the slave modport.
interface chirp_uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  o_frame_err;
   logic                  o_parity_err;
   logic                  o_busy;

   modport master (
      output o_data,
      output o_valid,
      output o_frame_err,
      output o_parity_err,
      output o_busy
   );

   modport slave (
      input o_data,
      input o_valid,
      input o_frame_err,
      input o_parity_err,
      input o_busy
   );
endinterface

// File: rtl/chirp_uart_rx.sv
// 16x oversampled UART byte receiver (8N1) for the chirp configuration link.
// Define CHIRP_UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a low sample on a tick
// ST_START | qualifying the start bit at its mid-point
// ST_DATA  | sampling DATA_WIDTH data bits, LSB first
// ST_PARITY| sampling the even-parity bit (parity build only)
// ST_STOP  | sampling the stop bit, issuing valid/error strobe
// ST_BREAK | stop bit was low; waiting for the line to return high
module chirp_uart_rx #(
   parameter int CLK_FREQ_HZ      = 10000000,
   parameter int BAUD_RATE        = 9600,
   parameter int OVERSAMPLE       = 16,
   parameter int DATA_WIDTH       = 8,
   parameter int DIVIDER_BITWIDTH = 7
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_rx,
   chirp_uart_rx_if.master  bus
);
   localparam int DIVIDER = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
   localparam int SC_W    = $clog2(OVERSAMPLE);
   localparam int IDX_W   = $clog2(DATA_WIDTH);

   localparam logic [DIVIDER_BITWIDTH-1:0] DIV_MAX   = DIVIDER_BITWIDTH'(DIVIDER - 1);
   localparam logic [SC_W-1:0]             SC_MID_ST = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0]             SC_MID    = SC_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0]            IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef CHIRP_UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t                  state_q, state_d;
   logic                    rx_meta_q, rx_s_q;
   logic [DIVIDER_BITWIDTH-1:0] div_q, div_d;
   logic [SC_W-1:0]         sc_q, sc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    ferr_q, ferr_d;
   logic                    perr_q, perr_d;
   logic                    tick;
   logic                    parity_bad;

`ifdef CHIRP_UART_RX_PARITY_EN
   logic                    par_q, par_d;
   // Even parity: data bits plus parity bit must XOR to zero.
   assign parity_bad = ^{shift_q, par_q};
`else
   assign parity_bad = 1'b0;
`endif

   assign tick  = (div_q == DIV_MAX);
   assign div_d = tick ? '0 : div_q + 1'b1;

   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
`ifdef CHIRP_UART_RX_PARITY_EN
      par_d   = par_q;
`endif
      if (tick) begin
         sc_d = (sc_q == SC_MID) ? '0 : sc_q + 1'b1;
         unique case (state_q)
            ST_IDLE: begin
               if (!rx_s_q) begin
                  sc_d    = '0;
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (sc_q == SC_MID_ST) begin
                  if (rx_s_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     sc_d    = '0;
                     idx_d   = '0;
                     state_d = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (sc_q == SC_MID) begin
                  shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                  idx_d   = idx_q + 1'b1;
                  if (idx_q == IDX_LAST) begin
`ifdef CHIRP_UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end
               end
            end
`ifdef CHIRP_UART_RX_PARITY_EN
            ST_PARITY: begin
               if (sc_q == SC_MID) begin
                  par_d   = rx_s_q;
                  state_d = ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
               if (sc_q == SC_MID) begin
                  if (!rx_s_q) begin
                     ferr_d  = 1'b1;
                     state_d = ST_BREAK;
                  end else if (parity_bad) begin
                     perr_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         div_q     <= '0;
         sc_q      <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
`ifdef CHIRP_UART_RX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
         div_q     <= div_d;
         sc_q      <= sc_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
`ifdef CHIRP_UART_RX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign bus.o_data       = data_q;
   assign bus.o_valid      = valid_q;
   assign bus.o_frame_err  = ferr_q;
   assign bus.o_parity_err = perr_q;
   assign bus.o_busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_chirp_uart_rx.sv
// Directed bench for chirp_uart_rx: frames are driven bit by bit and every strobe
// is matched against a queue of expected events filled when the frame is sent.
module tb_chirp_uart_rx;
   localparam int BIT_CLKS = 1040;

   logic clk = 1'b0;
   logic rst_n;
   logic rx;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [1:0] kind;
      logic [7:0] data;
   } ev_t;
   ev_t sb[$];

   chirp_uart_rx_if #(.DATA_WIDTH(8)) bus ();

   chirp_uart_rx dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_rx    (rx),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // kind: 0 = valid, 1 = frame error, 2 = parity error; data = o_data expected at the strobe
   task automatic push(input logic [1:0] kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef CHIRP_UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(stop);
   endtask

`ifdef CHIRP_UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] d, input logic par);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par);
      drive_bit(1'b1);
   endtask
`endif

   always @(negedge clk) begin
      ev_t        e;
      logic [1:0] kind_obs;
      if (rst_n && (bus.o_valid || bus.o_frame_err || bus.o_parity_err)) begin
         check("strobe_onehot",
               32'(bus.o_valid) + 32'(bus.o_frame_err) + 32'(bus.o_parity_err), 32'd1);
         kind_obs = bus.o_valid ? 2'd0 : (bus.o_frame_err ? 2'd1 : 2'd2);
         if (sb.size() == 0) begin
            check("unexpected_strobe", {29'd0, bus.o_valid, bus.o_frame_err, bus.o_parity_err}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("strobe_kind", 32'(kind_obs), 32'(e.kind));
            check("strobe_data", 32'(bus.o_data), 32'(e.data));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_data", 32'(bus.o_data), 32'h0);
      check("rst_valid", 32'(bus.o_valid), 32'h0);
      check("rst_ferr", 32'(bus.o_frame_err), 32'h0);
      check("rst_perr", 32'(bus.o_parity_err), 32'h0);
      check("rst_busy", 32'(bus.o_busy), 32'h0);
      @(posedge clk);
      rst_n = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);

      // plain byte
      push(2'd0, 8'hA5);
      send_frame(8'hA5, 1'b1);
      #1;
      check("a5_busy_low", 32'(bus.o_busy), 32'h0);
      check("a5_data", 32'(bus.o_data), 32'hA5);
      check("a5_seen", 32'(sb.size()), 32'd0);
      @(posedge clk);

      // short low glitch is rejected at the start-bit mid-point
      rx = 1'b0;
      repeat (300) @(posedge clk);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge clk);
      #1;
      check("glitch_busy", 32'(bus.o_busy), 32'h0);
      check("glitch_data", 32'(bus.o_data), 32'hA5);
      @(posedge clk);

      // low stop bit followed by a held-low line
      push(2'd1, 8'hA5);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(8'h3C >> i);
`ifdef CHIRP_UART_RX_PARITY_EN
      drive_bit(^8'h3C);
`endif
      rx = 1'b0;
      repeat (2 * BIT_CLKS) @(posedge clk);
      #1;
      check("break_busy", 32'(bus.o_busy), 32'h1);
      check("ferr_seen", 32'(sb.size()), 32'd0);
      repeat (BIT_CLKS) @(posedge clk);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge clk);
      #1;
      check("break_exit_busy", 32'(bus.o_busy), 32'h0);
      check("ferr_data_kept", 32'(bus.o_data), 32'hA5);
      @(posedge clk);
      push(2'd0, 8'h81);
      send_frame(8'h81, 1'b1);
      repeat (BIT_CLKS) @(posedge clk);
      check("after_break_81", 32'(bus.o_data), 32'h81);

      // back-to-back frames with no idle gap
      push(2'd0, 8'h00);
      push(2'd0, 8'hFF);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (BIT_CLKS) @(posedge clk);
      check("b2b_seen", 32'(sb.size()), 32'd0);
      check("b2b_data", 32'(bus.o_data), 32'hFF);

      // reset in the middle of data bit 4
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
      rx = 1'b1;
      repeat (BIT_CLKS / 2) @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_data", 32'(bus.o_data), 32'h0);
      check("midrst_valid", 32'(bus.o_valid), 32'h0);
      check("midrst_ferr", 32'(bus.o_frame_err), 32'h0);
      check("midrst_perr", 32'(bus.o_parity_err), 32'h0);
      check("midrst_busy", 32'(bus.o_busy), 32'h0);
      repeat (10) @(posedge clk);
      rst_n = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);
      push(2'd0, 8'h5A);
      send_frame(8'h5A, 1'b1);
      repeat (BIT_CLKS) @(posedge clk);
      check("fresh_5a_seen", 32'(sb.size()), 32'd0);
      check("fresh_5a_data", 32'(bus.o_data), 32'h5A);

`ifdef CHIRP_UART_RX_PARITY_EN
      push(2'd0, 8'h07);
      send_frame_par(8'h07, 1'b1);
      push(2'd2, 8'h07);
      send_frame_par(8'h07, 1'b0);
      repeat (BIT_CLKS) @(posedge clk);
      check("parity_seen", 32'(sb.size()), 32'd0);
      check("parity_data", 32'(bus.o_data), 32'h07);
`endif

      repeat (2 * BIT_CLKS) @(posedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
